// File: rtl/relm_vga_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | relm_vga_scan : programmable VGA timing with FIFO-fed, palette-mapped     |
// |                 pixel unpacker for the ReLM push/pop I/O bus              |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module relm_vga_scan #(
    parameter int WD       = 32,
    parameter int WAD      = 8,
    parameter int WBPP     = 4,
    parameter int PIX_DIV  = 2,
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_ACT0   = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_ACT0   = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [WD:0]   push_d_in,
    output logic          push_retry_out,
    input  logic [WD:0]   pal_d_in,
    input  logic [WD:0]   ctrl_d_in,
    input  logic [WD:0]   stat_d_in,
    output logic [WD:0]   stat_q_out,
    output logic [11:0]   rgb_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          frame_out
);

    localparam int c_PPW   = WD / WBPP;
    localparam int c_PPWB  = $clog2(c_PPW);
    localparam int c_DEPTH = 2 ** WAD;
    localparam int c_NPAL  = 2 ** WBPP;
    localparam int c_PDW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [c_PDW-1:0] r_pdiv;
    logic [11:0]      r_hcnt;
    logic [11:0]      r_vcnt;
    logic [11:0]      r_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame;
    logic             r_en;
    logic             r_en_req;
    logic [15:0]      r_ufl;
    logic [WD-1:0]    r_shift;
    logic [WD-1:0]    r_mem [c_DEPTH];
    logic [WAD-1:0]   r_wp;
    logic [WAD-1:0]   r_rp;
    logic [WAD:0]     r_cnt;
    logic [11:0]      r_pal [c_NPAL];

    logic             w_pe;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_frame;
    logic             w_hact;
    logic             w_vact;
    logic             w_show;
    logic [11:0]      w_hoff;
    logic             w_fetch;
    logic             w_empty;
    logic             w_full;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;
    logic             w_ufl;
    logic             w_sclr;
    logic [WD-1:0]    w_word;
    logic [WBPP-1:0]  w_pix;
    logic [WD:0]      w_stat;
    logic             w_unused;

    assign w_pe    = (r_pdiv == c_PDW'(PIX_DIV - 1));
    assign w_hwrap = (r_hcnt == 12'(H_TOTAL - 1));
    assign w_vwrap = (r_vcnt == 12'(V_TOTAL - 1));
    assign w_frame = w_pe & w_hwrap & w_vwrap;
    assign w_hact  = (r_hcnt >= 12'(H_ACT0)) && (r_hcnt < 12'(H_ACT0 + H_ACTIVE));
    assign w_vact  = (r_vcnt >= 12'(V_ACT0)) && (r_vcnt < 12'(V_ACT0 + V_ACTIVE));
    assign w_show  = w_hact & w_vact & r_en;
    assign w_hoff  = r_hcnt - 12'(H_ACT0);
    assign w_fetch = w_pe & w_show & (w_hoff[c_PPWB-1:0] == '0);

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (WAD+1)'(c_DEPTH));
    assign w_flush = ctrl_d_in[WD] & ctrl_d_in[0];
    assign w_push  = push_d_in[WD] & ~w_full & ~w_flush;
    assign w_pop   = w_fetch & ~w_empty;
    assign w_ufl   = w_fetch & w_empty;
    assign w_sclr  = stat_d_in[WD];

    // Show-ahead: the fetch pe displays the head word's top pixel directly.
    assign w_word = w_fetch ? (w_empty ? '0 : r_mem[r_rp]) : r_shift;
    assign w_pix  = w_word[WD-1 -: WBPP];

    assign push_retry_out = w_full;
    assign rgb_out        = r_rgb;
    assign hsync_out      = r_hsync;
    assign vsync_out      = r_vsync;
    assign frame_out      = r_frame;

    always_comb begin
        w_stat        = '0;
        w_stat[31:16] = r_ufl;
        w_stat[15]    = ~w_vact;
        w_stat[11:0]  = r_vcnt;
    end
    assign stat_q_out = w_stat;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= push_d_in[WD-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (pal_d_in[WD]) begin
            r_pal[pal_d_in[WBPP-1:0]] <= pal_d_in[19:8];
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_pdiv   <= '0;
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_rgb    <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_frame  <= 1'b0;
            r_en     <= 1'b0;
            r_en_req <= 1'b0;
            r_ufl    <= '0;
            r_shift  <= '0;
        end else begin
            r_pdiv  <= w_pe ? '0 : r_pdiv + 1'b1;
            r_frame <= w_frame;
            if (ctrl_d_in[WD]) begin
                r_en_req <= ctrl_d_in[1];
            end
            // Enable changes only on the frame boundary so a frame is never torn.
            if (w_frame) begin
                r_en <= r_en_req;
            end
            if (w_pe) begin
                r_hsync <= ~(r_hcnt < 12'(H_SYNC));
                r_vsync <= ~(r_vcnt < 12'(V_SYNC));
                r_rgb   <= w_show ? r_pal[w_pix] : 12'h000;
                if (w_show) begin
                    r_shift <= w_word << WBPP;
                end
                if (w_hwrap) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_vwrap ? 12'h000 : r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
            if (w_sclr) begin
                r_ufl <= w_ufl ? 16'h0001 : 16'h0000;
            end else if (w_ufl && (r_ufl != 16'hFFFF)) begin
                r_ufl <= r_ufl + 1'b1;
            end
        end
    end

    assign w_unused = ^{pal_d_in, ctrl_d_in, stat_d_in[WD-1:0], w_hoff};

endmodule
`default_nettype wire

// File: tb/tb_relm_vga_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_relm_vga_scan : directed table-driven bench for relm_vga_scan          |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_relm_vga_scan;

    localparam int WD = 32;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [WD:0] push4 = '0, pal4 = '0, ctrl4 = '0, stat4 = '0;
    logic [WD:0] push8 = '0, pal8 = '0, ctrl8 = '0, stat8 = '0;
    logic [WD:0] statq4, statq8;
    logic        retry4, retry8, hs4, vs4, fr4, hs8, vs8, fr8;
    logic [11:0] rgb4, rgb8;

    int total = 0;
    int bad   = 0;
    int pos   = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [95:0] exp;
    } vec_t;
    vec_t tv [4];

    always #5 clk = ~clk;

    relm_vga_scan #(
        .WD(32), .WAD(2), .WBPP(4), .PIX_DIV(2),
        .H_TOTAL(20), .H_SYNC(2), .H_ACT0(4), .H_ACTIVE(16),
        .V_TOTAL(6), .V_SYNC(1), .V_ACT0(2), .V_ACTIVE(2)
    ) u_dut4 (
        .clk(clk), .rst_in(rst_in), .push_d_in(push4), .push_retry_out(retry4),
        .pal_d_in(pal4), .ctrl_d_in(ctrl4), .stat_d_in(stat4), .stat_q_out(statq4),
        .rgb_out(rgb4), .hsync_out(hs4), .vsync_out(vs4), .frame_out(fr4)
    );

    relm_vga_scan #(
        .WD(32), .WAD(2), .WBPP(8), .PIX_DIV(2),
        .H_TOTAL(20), .H_SYNC(2), .H_ACT0(4), .H_ACTIVE(16),
        .V_TOTAL(6), .V_SYNC(1), .V_ACT0(2), .V_ACTIVE(2)
    ) u_dut8 (
        .clk(clk), .rst_in(rst_in), .push_d_in(push8), .push_retry_out(retry8),
        .pal_d_in(pal8), .ctrl_d_in(ctrl8), .stat_d_in(stat8), .stat_q_out(statq8),
        .rgb_out(rgb8), .hsync_out(hs8), .vsync_out(vs8), .frame_out(fr8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic goto(input int t);
        while (pos < t) tick();
    endtask

    // Clock edge (counted from the frame_out edge) at which line v, pixel h appears.
    function automatic int edge_t(input int v, input int h);
        return 2 + 2 * (20 * v + h);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return hs4;
            1:       return vs4;
            2:       return fr4;
            default: return fr8;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL wait_timeout sel=%0d", sel);
        end
    endtask

    task automatic wait_frame(input int sel);
        int n;
        tick();
        wait_level(sel, 1'b1, n);
        pos = 0;
    endtask

    task automatic push4w(input logic [31:0] w);
        push4 = {1'b1, w};
        tick();
        push4 = '0;
    endtask

    task automatic push8w(input logic [31:0] w);
        push8 = {1'b1, w};
        tick();
        push8 = '0;
    endtask

    initial begin
        int lo, hi, n, nz;
        logic [95:0] e8;

        tv[0] = '{word: 32'h0123_4567, exp: 96'h000_111_222_333_444_555_666_777};
        tv[1] = '{word: 32'h89AB_CDEF, exp: 96'h888_999_AAA_BBB_CCC_DDD_EEE_FFF};
        tv[2] = '{word: 32'hFEDC_BA98, exp: 96'hFFF_EEE_DDD_CCC_BBB_AAA_999_888};
        tv[3] = '{word: 32'h7654_3210, exp: 96'h777_666_555_444_333_222_111_000};

        // Reset state
        repeat (3) tick();
        chk("rst_rgb", rgb4, 0);
        chk("rst_hsync", hs4, 1);
        chk("rst_vsync", vs4, 1);
        chk("rst_retry", retry4, 0);
        chk("rst_frame", fr4, 0);
        chk("rst_ufl", statq4[31:16], 0);
        rst_in = 1'b0;

        // Sync and frame timing
        wait_level(0, 1'b0, n);
        wait_level(0, 1'b1, lo);
        wait_level(0, 1'b0, hi);
        chk("hsync_low_clks", lo, 4);
        chk("hsync_period", lo + hi, 40);
        wait_level(2, 1'b1, n);
        tick();
        chk("frame_width", fr4, 0);
        wait_level(2, 1'b1, n);
        chk("frame_period", n + 1, 240);
        wait_level(1, 1'b0, n);
        wait_level(1, 1'b1, lo);
        chk("vsync_low_clks", lo, 40);

        // Palette i*0x111, odd entries addressed through index+16 (mod 16)
        for (int i = 0; i < 16; i++) begin
            pal4 = {1'b1, 12'h000, 12'(i * 'h111), 8'(i + ((i % 2 == 1) ? 16 : 0))};
            tick();
        end
        pal4 = '0;

        // FIFO full / retry / flush
        for (int i = 0; i < 4; i++) push4w(32'hDEAD_0000 + i);
        chk("retry_full", retry4, 1);
        push4w(32'hBEEF_BEEF);
        chk("retry_still_full", retry4, 1);
        ctrl4 = {1'b1, 32'h1};
        tick();
        ctrl4 = '0;
        chk("retry_after_flush", retry4, 0);
        push4w(32'h1111_1111);
        push4 = {1'b1, 32'h2222_2222};
        ctrl4 = {1'b1, 32'h1};
        tick();
        push4 = '0;
        ctrl4 = '0;
        for (int i = 0; i < 3; i++) push4w(tv[i].word);
        chk("retry_3words", retry4, 0);
        push4w(tv[3].word);
        chk("retry_4words", retry4, 1);

        // Enable requested mid-frame: nothing shown until next frame start
        wait_frame(4);
        goto(100);
        ctrl4 = {1'b1, 32'h2};
        tick();
        ctrl4 = '0;
        nz = 0;
        n = 0;
        while (fr4 !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (rgb4 !== 12'h000) nz++;
        end
        chk("disabled_rgb_nonzero", nz, 0);
        chk("frame_after_enable", n < 300, 1);
        chk("fifo_untouched", retry4, 1);
        pos = 0;

        // Data frame (frame_out just seen)
        chk("stat_vblank", statq4[15:0], 16'h8000);
        for (int v = 2; v < 4; v++) begin
            for (int h = 4; h < 20; h++) begin
                int e, wi, p;
                e  = edge_t(v, h);
                wi = (v - 2) * 2 + (h - 4) / 8;
                p  = (h - 4) % 8;
                if (v == 2 && h == 4) begin
                    goto(e - 1);
                    push4 = {1'b1, 32'hFFFF_FFFF};
                end
                goto(e);
                push4 = '0;
                chk($sformatf("pix4 v%0d h%0d", v, h), rgb4, tv[wi].exp[95 - 12 * p -: 12]);
                if (v == 2 && h == 4) begin
                    chk("retry_after_pop_full", retry4, 0);
                    chk("stat_active", statq4[15:0], 16'h0002);
                end
            end
        end
        chk("ufl_after_data", statq4[31:16], 0);

        // Underflow frame, palette[0] changed
        wait_frame(4);
        pal4 = {1'b1, 12'h000, 12'h123, 8'h00};
        tick();
        pal4 = '0;
        for (int h = 4; h < 20; h++) begin
            goto(edge_t(2, h));
            chk($sformatf("ufl_pix h%0d", h), rgb4, 12'h123);
        end
        chk("ufl_line2", statq4[31:16], 2);
        goto(edge_t(3, 4));
        chk("ufl_line3_first", statq4[31:16], 3);
        goto(edge_t(3, 19));
        chk("ufl_frame", statq4[31:16], 4);

        // Stat clear + underflow, push on empty with simultaneous underflow
        wait_frame(4);
        goto(edge_t(2, 4) - 1);
        stat4 = {1'b1, 32'h0};
        push4 = {1'b1, tv[0].word};
        tick();
        stat4 = '0;
        push4 = '0;
        chk("clear_and_inc", statq4[31:16], 1);
        for (int h = 4; h < 20; h++) begin
            logic [11:0] ex;
            if (h < 13) ex = 12'h123;
            else        ex = 12'((h - 12) * 'h111);
            goto(edge_t(2, h));
            chk($sformatf("push_on_empty h%0d", h), rgb4, ex);
        end
        goto(edge_t(3, 19));
        chk("ufl_after_clear", statq4[31:16], 3);
        stat4 = {1'b1, 32'h0};
        tick();
        stat4 = '0;
        chk("ufl_cleared", statq4[31:16], 0);

        // 8bpp instance
        pal8 = {1'b1, 12'h000, 12'hF0F, 8'hA5};
        tick();
        pal8 = {1'b1, 12'h000, 12'h0F0, 8'h3C};
        tick();
        pal8 = {1'b1, 12'h000, 12'h000, 8'h00};
        tick();
        pal8 = '0;
        push8w(32'hA5A5_A5A5);
        push8w(32'h3CA5_003C);
        ctrl8 = {1'b1, 32'h2};
        tick();
        ctrl8 = '0;
        wait_frame(8);
        e8 = 96'hF0F_F0F_F0F_F0F_0F0_F0F_000_0F0;
        for (int h = 4; h < 20; h++) begin
            logic [11:0] ex;
            if (h < 12) ex = e8[95 - 12 * (h - 4) -: 12];
            else        ex = 12'h000;
            goto(edge_t(2, h));
            chk($sformatf("pix8 h%0d", h), rgb8, ex);
        end

        // Reset mid-line
        wait_frame(4);
        goto(edge_t(2, 10));
        chk("pre_reset_rgb", rgb4, 12'h123);
        rst_in = 1'b1;
        #1;
        chk("midrst_rgb", rgb4, 0);
        chk("midrst_hsync", hs4, 1);
        chk("midrst_vsync", vs4, 1);
        chk("midrst_retry", retry4, 0);
        chk("midrst_stat", statq4[31:0], 32'h0000_8000);
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
